// File: rtl/top_level_pkg.sv
// Shared types and constants for the SECDED batch decoder.
// Holds the FSM state enum, layout constants and flag encodings.
package top_level_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_HI,
        WR_LO,
        FIN
    } state_t;

    localparam int WORDS = 15;
    localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

    localparam logic [7:0] OUT_BASE = 8'd0;
    localparam logic [7:0] IN_BASE  = 8'd30;

    localparam logic [1:0] FLG_OK  = 2'b00;
    localparam logic [1:0] FLG_SEC = 2'b01;
    localparam logic [1:0] FLG_DED = 2'b10;

    // XOR of the positions of all set bits 1..15.
    function automatic logic [3:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ 4'(k);
        end
        return s;
    endfunction

    // Data bits sit at the non-power-of-two positions.
    function automatic logic [10:0] extract(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256 x 8 data memory: combinational read, synchronous write.
// Ports: clk, we, addr[7:0], wdata[7:0] in; rdata[7:0] out.
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    assign rdata = core[addr];

    always_ff @(posedge clk) begin
        if (we) core[addr] <= wdata;
    end

endmodule

// File: rtl/top_level.sv
// Decodes 15 Hamming SECDED words from memory and writes results back.
// Ports: clk, start (sync reset + launch) in; done out.
module top_level
    import top_level_pkg::*;
(
    input  logic clk,
    input  logic start,
    output logic done
);

    state_t     state = IDLE;
    state_t     next;
    logic [3:0] idx   = 4'd0;
    logic [7:0] lo_q;
    logic [7:0] hi_q;

    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    logic [15:0] w;
    logic [15:0] fixed;
    logic [3:0]  syn;
    logic        par;
    logic [1:0]  flags;
    logic [15:0] res;
    logic [7:0]  off;

    data_mem dm1 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // State register, word index and byte latches.
    always_ff @(posedge clk) begin
        if (start) begin
            state <= RD_LO;
            idx   <= 4'd0;
        end else begin
            state <= next;
            if (state == RD_LO) lo_q <= rdata;
            if (state == RD_HI) hi_q <= rdata;
            if (state == WR_LO && idx != LAST_IDX)
                idx <= idx + 4'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:  next = IDLE;
            RD_LO: next = RD_HI;
            RD_HI: next = WR_HI;
            WR_HI: next = WR_LO;
            WR_LO: next = (idx == LAST_IDX) ? FIN : RD_LO;
            FIN:   next = FIN;
            default: next = IDLE;
        endcase
    end

    // Decode of the latched word.
    always_comb begin
        w     = {hi_q, lo_q};
        syn   = syndrome(w);
        par   = ^w;
        fixed = w;
        flags = FLG_OK;
        if (par) begin
            // Syndrome 0 with odd parity means bit 0 itself flipped.
            fixed[syn] = ~w[syn];
            flags      = FLG_SEC;
        end else if (syn != 4'd0) begin
            flags = FLG_DED;
        end
        res = {flags, 3'b000, extract(fixed)};
    end

    // Outputs: memory address, write strobe and data, done.
    always_comb begin
        off   = {3'b000, idx, 1'b0};
        addr  = IN_BASE + off;
        wdata = 8'd0;
        we    = 1'b0;
        done  = (state == FIN);
        unique case (state)
            RD_LO: addr = IN_BASE + off;
            RD_HI: addr = IN_BASE + off + 8'd1;
            WR_HI: begin
                addr  = OUT_BASE + off + 8'd1;
                wdata = res[15:8];
                we    = ~start;
            end
            WR_LO: begin
                addr  = OUT_BASE + off;
                wdata = res[7:0];
                we    = ~start;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level SECDED batch decoder.
// Stimulus pushes expected outputs; a monitor checks on done.
module tb_top_level;

    logic clk = 1'b0;
    logic start = 1'b0;
    logic done;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  img [30];
    logic [15:0] wv [15];
    logic [15:0] ev [15];
    logic        done_d = 1'b0;

    top_level dut (
        .clk   (clk),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference encoder built from the code definition.
    function automatic logic [15:0] enc(input logic [10:0] d);
        logic [15:0] x;
        logic [3:0]  s;
        int          n;
        x = 16'd0;
        n = 0;
        for (int p = 3; p < 16; p++) begin
            if (p != 4 && p != 8) begin
                x[p] = d[n];
                n++;
            end
        end
        s = 4'd0;
        for (int k = 1; k < 16; k++) if (x[k]) s = s ^ 4'(k);
        for (int b = 0; b < 4; b++) if (s[b]) x[1 << b] = 1'b1;
        x[0] = ^x[15:1];
        return x;
    endfunction

    // Monitor: on each rising done, pop 15 expectations.
    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] got;
        logic        ok;
        if (done && !done_d) begin
            for (int i = 0; i < 15; i++) begin
                got = {dut.dm1.core[2*i+1], dut.dm1.core[2*i]};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out%0d: got %h, no expectation", i, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL out%0d: got %h, want %h", i, got, e);
                    end
                end
            end
            ok = 1'b1;
            for (int a = 0; a < 30; a++)
                if (dut.dm1.core[30+a] !== img[a]) ok = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL input_area: got modified, want preserved");
            end
        end
        done_d = done;
    end

    task automatic load();
        for (int i = 0; i < 15; i++) begin
            dut.dm1.core[30+2*i] = wv[i][7:0];
            dut.dm1.core[31+2*i] = wv[i][15:8];
            img[2*i]   = wv[i][7:0];
            img[2*i+1] = wv[i][15:8];
            dut.dm1.core[2*i]   = 8'hA5;
            dut.dm1.core[2*i+1] = 8'h5A;
            exp_q.push_back(ev[i]);
        end
    endtask

    task automatic check_done(input string nm, input logic want);
        vectors++;
        if (done !== want) begin
            miscompares++;
            $display("FAIL %s: done=%b, want %b", nm, done, want);
        end
    endtask

    // Wait for done after release, then let the monitor run.
    task automatic wait_done();
        int c;
        c = 0;
        for (int k = 1; k <= 61; k++) begin
            @(posedge clk);
            #1;
            c = k;
            if (done) break;
        end
        vectors++;
        if (!done || c != 60) begin
            miscompares++;
            $display("FAIL done_latency: got %0d cycles (done=%b), want 60",
                     c, done);
        end
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares += exp_q.size();
            $display("FAIL scoreboard: %0d left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_done("done_in_start", 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic void mixed(input int rot);
        logic [15:0] iw [5];
        logic [15:0] ow [5];
        iw = '{16'h0020, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h0028};
        ow = '{16'h4000, 16'h4000, 16'h07FF, 16'h47FF, 16'h8003};
        for (int i = 0; i < 15; i++) begin
            wv[i] = iw[(i + rot) % 5];
            ev[i] = ow[(i + rot) % 5];
        end
    endfunction

    function automatic void randomize_words();
        logic [10:0] d;
        logic [15:0] x;
        int          n;
        int          b1;
        int          b2;
        for (int i = 0; i < 15; i++) begin
            d  = 11'($urandom);
            x  = enc(d);
            n  = int'($urandom_range(0, 2));
            b1 = int'($urandom_range(0, 15));
            b2 = (b1 + int'($urandom_range(1, 15))) % 16;
            if (n >= 1) x[b1] = ~x[b1];
            if (n == 2) x[b2] = ~x[b2];
            wv[i] = x;
            if (n == 0)      ev[i] = {2'b00, 3'b000, d};
            else if (n == 1) ev[i] = {2'b01, 3'b000, d};
            else ev[i] = {2'b10, 3'b000, x[15:9], x[7:5], x[3]};
        end
    endfunction

    initial begin
        #1;
        check_done("power_up", 1'b0);

        // All zero words.
        for (int i = 0; i < 15; i++) begin
            wv[i] = 16'h0000;
            ev[i] = 16'h0000;
        end
        load();
        pulse_start();
        wait_done();

        // Directed single/double/clean patterns.
        mixed(0);
        load();
        pulse_start();
        wait_done();

        // Random words, restart 20 cycles into the run.
        randomize_words();
        load();
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check_done("mid_run", 1'b0);
        pulse_start();
        wait_done();

        // Restart from FIN with new inputs; done must drop.
        check_done("fin_hold", 1'b1);
        mixed(2);
        load();
        pulse_start();
        wait_done();

        // Second random batch.
        randomize_words();
        load();
        pulse_start();
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check_done("fin_held", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 SHALL have no parameters; word count 15, input base address 30 and output base address 0 are fixed constants.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: start  input  1  synchronous active-high reset that also launches the program.
REQ-004 SHALL have port: done  output  1  high when all 15 words are processed; held until next start.
REQ-005 SHALL contain a data-memory instance named dm1 holding a 256 x 8-bit array named core, directly accessible by hierarchical reference for preload and readback.

Function
REQ-006 SHALL decode 15 Hamming SECDED words; word i (0..14) = {core[31+2i], core[30+2i]} (high byte, low byte), bit positions 15..0.
REQ-007 SHALL compute syndrome S[3:0] = XOR of the indices of all set bits at positions 1..15, and overall parity P = XOR of all 16 bits.
REQ-008 SHALL classify each word: S==0 and P==0 -> no error, flags 2'b00; P==1 -> single error, flags 2'b01, invert bit S (S==0 means bit 0 flipped, data unaffected); S!=0 and P==0 -> double error, flags 2'b10, no correction.
REQ-009 SHALL extract data d[11:1] from the (corrected) word: d[11:5]=w[15:9], d[4:2]=w[7:5], d[1]=w[3].
REQ-010 SHALL write result {flags[1:0], 3'b000, d[11:1]} with the high byte to core[2i+1] and the low byte to core[2i].
REQ-011 SHALL use FSM states IDLE, RD_LO, RD_HI, WR_HI, WR_LO, FIN; 4 cycles per word, 60 cycles start-release to done.
REQ-012 SHALL transition RD_LO->RD_HI->WR_HI->WR_LO; from WR_LO go to RD_LO with i+1 if i<14, else FIN.
REQ-013 SHALL latch the low byte in RD_LO and the high byte in RD_HI; decode SHALL be combinational from the latched bytes.
REQ-014 SHALL hold FIN with done=1 indefinitely until start.
REQ-015 SHALL use combinational memory reads and synchronous writes, one write per cycle, write enable only in WR_HI/WR_LO.
REQ-016 SHALL never write addresses 30..59 during a run; the input area is preserved.

Reset
REQ-017 SHALL, while start=1 at a clock edge, force state=RD_LO, i=0, done=0 and suppress memory writes; processing begins on the first edge with start=0.
REQ-018 SHALL, if start is asserted mid-run or in FIN, abandon the run and restart from word 0; partial outputs are later overwritten.
REQ-019 SHALL power up in IDLE with done=0 (initializer), leaving IDLE only on start.
REQ-020 SHALL NOT clear memory on start.

Structure
REQ-021 SHALL place state enum, word count (15), base addresses (0, 30) and flag encodings in a shared package.
REQ-022 SHALL implement dm1 as sub-module data_mem (256x8, array core, async read, sync write); the decoder/FSM SHALL reside in top_level.

Verification
REQ-023 SHALL check: all 15 input words 0x0000 -> every output 0x0000, done high within 61 cycles of start release.
REQ-024 SHALL check: input 0x0020 (bit 5 flipped) -> output 0x4000; input 0x0001 (bit 0 flipped) -> output 0x4000.
REQ-025 SHALL check: input 0xFFFF (d=0x7FF, clean) -> output 0x07FF; input 0x7FFF -> output 0x47FF.
REQ-026 SHALL check: input 0x0028 (bits 3 and 5 flipped) -> output 0x8003 (MSB=1, data uncorrected).
REQ-027 SHALL check: start reasserted at cycle 20 of a run -> done drops, run restarts, final outputs match expected values, addresses 30..59 unchanged.
REQ-028 SHALL check: 15 random encoded words with random 0/1/2-bit corruption -> 15/15 outputs correct per REQ-008/REQ-010.
